debounce_edge_det: RTL

DEBOUNCE_EDGE_DET -- requirements
Module: debounce_edge_det

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_edge_det_sync_2ff.sv | 21 ++
 rtl/debounce_edge_det.sv | 115 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer / edge detector.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  localparam int STABLE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/debounce_edge_det_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_edge_det.sv
// Debounces a raw button input and emits one-cycle rise/fall pulses
// when a new level has been held for STABLE_CYCLES synchronized samples.
module debounce_edge_det
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic en_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  generate
    if (STABLE_CYCLES < 2) begin : g_bad_param
      $error("debounce_edge_det: STABLE_CYCLES must be at least 2");
    end
  endgenerate

  logic          sync_q;
  state_t        state;
  logic [CW-1:0] cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_i),
    .q     (sync_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STABLE_LO;
      cnt     <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (!en_i) begin
        // Disabled: park in the stable state that matches the committed level.
        state  <= level_o ? STABLE_HI : STABLE_LO;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          STABLE_LO: begin
            if (sync_q) begin
              state  <= CHK_HI;
              cnt    <= ONE;
              busy_o <= 1'b1;
            end else begin
              cnt <= '0;
            end
          end
          CHK_HI: begin
            if (!sync_q) begin
              state  <= STABLE_LO;
              cnt    <= '0;
              busy_o <= 1'b0;
            end else if (cnt == LAST) begin
              state   <= STABLE_HI;
              cnt     <= '0;
              level_o <= 1'b1;
              rise_o  <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STABLE_HI: begin
            if (!sync_q) begin
              state  <= CHK_LO;
              cnt    <= ONE;
              busy_o <= 1'b1;
            end else begin
              cnt <= '0;
            end
          end
          CHK_LO: begin
            if (sync_q) begin
              state  <= STABLE_HI;
              cnt    <= '0;
              busy_o <= 1'b0;
            end else if (cnt == LAST) begin
              state   <= STABLE_LO;
              cnt     <= '0;
              level_o <= 1'b0;
              fall_o  <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state  <= STABLE_LO;
            cnt    <= '0;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
